// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared defaults and reference rounding helper for the filter output stage
package filter_pkg;

  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 8;
  localparam int SHIFT_DEF = 4;
  localparam int SKIP_DEF  = 8;
  localparam int DEPTH_DEF = 8;
  localparam int DROP_MAX  = 255;

  // Round-half-up arithmetic right shift followed by clamp to a signed out_w word.
  function automatic int sat_round(input int in_v, input int shift, input int out_w);
    int t;
    int hi;
    int lo;
    t  = (in_v + (1 << (shift - 1))) >>> shift;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    if (t > hi) begin
      return hi;
    end else if (t < lo) begin
      return lo;
    end
    return t;
  endfunction

endpackage

// File: rtl/filter_out_stage_if.sv
// rtl/filter_out_stage_if.sv - sample input, word output and status bundle of filter_out_stage
interface filter_out_stage_if
  import filter_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  logic [IN_W-1:0]          in_val;
  logic                     in_en;
  logic [OUT_W-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sat_flag;
  logic [7:0]               drop_cnt;
  logic [$clog2(DEPTH):0]   level;

  modport slave (
    input  in_val, in_en, out_ready,
    output out_data, out_valid, sat_flag, drop_cnt, level
  );

  modport master (
    output in_val, in_en, out_ready,
    input  out_data, out_valid, sat_flag, drop_cnt, level
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with explicit occupancy counter
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          push;
  logic          pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign pop   = rd_en && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign push  = wr_en && (!full || pop);

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/filter_out_stage.sv
// rtl/filter_out_stage.sv - warm-up skip, rounded rescale/saturate and buffered output of the IIR stream
module filter_out_stage
  import filter_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int SKIP  = SKIP_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic               clk,
  input logic               rst,
  filter_out_stage_if.slave bus
);

  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam logic signed [IN_W:0] HALF  = (IN_W + 1)'(2 ** (SHIFT - 1));
  localparam logic signed [IN_W:0] MAX_S = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [IN_W:0] MIN_S = (IN_W + 1)'(-(2 ** (OUT_W - 1)));

  logic [SKIP_W-1:0]      skip_q, skip_d;
  logic                   in_vld_q;
  logic [IN_W-1:0]        in_q;
  logic                   stg_vld_q;
  logic [OUT_W-1:0]       stg_q;
  logic                   sat_q;
  logic [7:0]             drop_q, drop_d;
  logic [OUT_W-1:0]       hold_q;

  logic                   accept;
  logic signed [IN_W:0]   t;
  logic signed [IN_W:0]   s;
  logic                   clamp_hi;
  logic                   clamp_lo;
  logic [OUT_W-1:0]       word;

  logic [OUT_W-1:0]       fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;

  assign accept = bus.in_en && (skip_q == '0);

  always_comb begin
    skip_d = skip_q;
    if (bus.in_en && (skip_q != '0)) skip_d = skip_q - 1'b1;
  end

  // One guard bit keeps the rounding add from wrapping near the positive limit.
  always_comb begin
    t        = $signed({in_q[IN_W-1], in_q}) + HALF;
    s        = t >>> SHIFT;
    clamp_hi = (s > MAX_S);
    clamp_lo = (s < MIN_S);
    word     = s[OUT_W-1:0];
    if (clamp_hi)      word = MAX_S[OUT_W-1:0];
    else if (clamp_lo) word = MIN_S[OUT_W-1:0];
  end

  assign pop = bus.out_ready && !fifo_empty;

  always_comb begin
    drop_d = drop_q;
    if (stg_vld_q && fifo_full && !pop && (drop_q != 8'(DROP_MAX))) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q    <= SKIP_W'(SKIP);
      in_vld_q  <= 1'b0;
      in_q      <= '0;
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
      sat_q     <= 1'b0;
      drop_q    <= '0;
      hold_q    <= '0;
    end else begin
      skip_q    <= skip_d;
      in_vld_q  <= accept;
      if (accept) in_q <= bus.in_val;
      stg_vld_q <= in_vld_q;
      if (in_vld_q) stg_q <= word;
      if (in_vld_q && (clamp_hi || clamp_lo)) sat_q <= 1'b1;
      drop_q    <= drop_d;
      if (!fifo_empty) hold_q <= fifo_rd_data;
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (stg_vld_q),
    .wr_data (stg_q),
    .rd_en   (bus.out_ready),
    .rd_data (fifo_rd_data),
    .level   (bus.level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? hold_q : fifo_rd_data;
  assign bus.sat_flag  = sat_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_filter_out_stage.sv
// tb/tb_filter_out_stage.sv - randomized self-checking bench for filter_out_stage against a queue model
module tb_filter_out_stage;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int SHIFT = 4;
  localparam int SKIP  = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  filter_out_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  filter_out_stage #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT),
    .SKIP  (SKIP),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int due;
    int word;
  } fl_t;

  int  q[$];
  fl_t fl[$];
  int  skip_m;
  int  drop_m;
  bit  sat_m;
  int  cyc = 0;

  task automatic model_reset();
    q.delete();
    fl.delete();
    skip_m = SKIP;
    drop_m = 0;
    sat_m  = 1'b0;
  endtask

  // Floor division of (v + half) by 2^SHIFT, then clamp to the signed OUT_W range.
  function automatic int model_word(input int v, output bit sat);
    int t, s, div, hi, lo;
    div = 1 << SHIFT;
    hi  = (1 << (OUT_W - 1)) - 1;
    lo  = -(1 << (OUT_W - 1));
    t   = v + div / 2;
    if (t >= 0) s = t / div;
    else        s = -((-t + div - 1) / div);
    sat = 1'b0;
    if (s > hi) begin
      s = hi; sat = 1'b1;
    end else if (s < lo) begin
      s = lo; sat = 1'b1;
    end
    return s;
  endfunction

  function automatic int rnd_sample();
    logic signed [15:0] v;
    int r;
    v = 16'($urandom);
    r = v;
    return r;
  endfunction

  task automatic step(input bit en, input int val, input bit rdy);
    bit  pop, full_b, arrive, s;
    fl_t e;
    bus.in_en     = en;
    bus.in_val    = IN_W'(val);
    bus.out_ready = rdy;
    check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check_eq("level", 32'(bus.level), 32'(q.size()));
    check_eq("drop_cnt", 32'(bus.drop_cnt), 32'(drop_m));
    if (q.size() != 0) check_eq("out_data", 32'(bus.out_data), 32'(q[0] & 32'hFF));
    pop    = (q.size() != 0) && rdy;
    full_b = (q.size() == DEPTH);
    arrive = 1'b0;
    if (fl.size() != 0 && fl[0].due == cyc) begin
      e      = fl.pop_front();
      arrive = 1'b1;
    end
    if (pop) void'(q.pop_front());
    if (arrive) begin
      if (full_b && !pop) begin
        if (drop_m < 255) drop_m++;
      end else begin
        q.push_back(e.word);
      end
    end
    if (en) begin
      if (skip_m > 0) begin
        skip_m--;
      end else begin
        e.word = model_word(val, s);
        e.due  = cyc + 2;
        sat_m  = sat_m | s;
        fl.push_back(e);
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int t2[5];
    t2 = '{2047, -2100, -24, 8, 7};
    bus.in_en     = 1'b0;
    bus.in_val    = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_level", 32'(bus.level), 32'd0);
    check_eq("rst_drop", 32'(bus.drop_cnt), 32'd0);
    check_eq("rst_sat", 32'(bus.sat_flag), 32'd0);
    check_eq("rst_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;

    // Warm-up: eight discarded strobes, then 100 -> 6
    repeat (8) step(1'b1, 1000, 1'b1);
    step(1'b1, 100, 1'b1);
    step(1'b0, 0, 1'b1);
    check_eq("warm_valid_early", 32'(bus.out_valid), 32'd0);
    step(1'b0, 0, 1'b1);
    check_eq("warm_valid", 32'(bus.out_valid), 32'd1);
    check_eq("warm_word", 32'(bus.out_data), 32'h06);
    repeat (3) step(1'b0, 0, 1'b1);
    check_eq("warm_sat", 32'(bus.sat_flag), 32'd0);

    // Rounding and saturation corners
    for (int i = 0; i < 5; i++) step(1'b1, t2[i], 1'b1);
    repeat (4) step(1'b0, 0, 1'b1);
    check_eq("round_sat", 32'(bus.sat_flag), 32'd1);

    // Backpressure: ten samples into eight slots
    for (int k = 1; k <= 10; k++) step(1'b1, 16 * k, 1'b0);
    repeat (2) step(1'b0, 0, 1'b0);
    check_eq("bp_level", 32'(bus.level), 32'd8);
    check_eq("bp_drop", 32'(bus.drop_cnt), 32'd2);
    repeat (10) step(1'b0, 0, 1'b1);

    // Full FIFO with simultaneous push and pop
    repeat (10) step(1'b1, rnd_sample(), 1'b0);
    repeat (20) step(1'b1, rnd_sample(), 1'b1);
    check_eq("full_level", 32'(bus.level), 32'd8);
    check_eq("full_drop", 32'(bus.drop_cnt), 32'd2);
    repeat (12) step(1'b0, 0, 1'b1);
    check_eq("full_sat", 32'(bus.sat_flag), 32'(sat_m));

    // Reset with data buffered and in flight
    repeat (4) step(1'b1, rnd_sample(), 1'b0);
    step(1'b0, 0, 1'b0);
    check_eq("pre_rst_level", 32'(bus.level), 32'd3);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_level", 32'(bus.level), 32'd0);
    check_eq("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
    check_eq("mid_rst_sat", 32'(bus.sat_flag), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (8) step(1'b1, rnd_sample(), 1'b1);
    step(1'b1, 160, 1'b1);
    repeat (4) step(1'b0, 0, 1'b1);

    // Sink toggling ready, sparse strobes
    for (int i = 0; i < 36; i++) step(i % 3 == 0, rnd_sample(), i % 2 == 0);
    repeat (6) step(1'b0, 0, 1'b1);
    check_eq("idle_drop", 32'(bus.drop_cnt), 32'd0);

    // Random traffic
    repeat (400) step(bit'($urandom_range(0, 1)), rnd_sample(), $urandom_range(0, 3) != 0);
    repeat (6) step(1'b0, 0, 1'b1);
    check_eq("rand_sat", 32'(bus.sat_flag), 32'(sat_m));

    // Drop counter saturation
    repeat (280) step(1'b1, rnd_sample(), 1'b0);
    check_eq("drop_saturated", 32'(bus.drop_cnt), 32'd255);
    repeat (12) step(1'b0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
